// File: rtl/sram_responder_pkg.sv
// Shared types, defaults and the byte-merge helper for the SRAM responder slice.
package sram_responder_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    localparam logic [WORD_W-1:0] OOR_DATA_DEF = 32'hDEAD_BEEF;
    localparam int                CNT_W_DEF    = 32;

    // Replace only the bytes selected by mask; other bytes keep the old value.
    function automatic logic [WORD_W-1:0] byte_merge(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [BE_W-1:0]   mask
    );
        logic [WORD_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < BE_W; b++) begin
            if (mask[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_responder_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; sticks at all-ones.
module sram_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/sram_responder.sv
// Slave end of the inst_sram/data_sram buses: one shared word array, one-cycle
// read-first reads, byte-enabled writes, sticky out-of-range flag and access counters.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int                DEPTH    = 16384,
    parameter int                AW       = 14,
    parameter logic [WORD_W-1:0] OOR_DATA = OOR_DATA_DEF,
    parameter int                CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_sram_en,
    input  logic [BE_W-1:0]   inst_sram_we,
    input  logic [31:0]       inst_sram_addr,
    input  logic [WORD_W-1:0] inst_sram_wdata,
    output logic [WORD_W-1:0] inst_sram_rdata,

    input  logic              data_sram_en,
    input  logic [BE_W-1:0]   data_sram_we,
    input  logic [31:0]       data_sram_addr,
    input  logic [WORD_W-1:0] data_sram_wdata,
    output logic [WORD_W-1:0] data_sram_rdata,

    output logic              oor_err,
    output logic [CNT_W-1:0]  inst_rd_cnt,
    output logic [CNT_W-1:0]  data_rd_cnt,
    output logic [CNT_W-1:0]  data_wr_cnt
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];

    logic [AW-1:0]    inst_idx;
    logic [AW-1:0]    data_idx;
    logic [IDX_W-1:0] inst_mem_idx;
    logic [IDX_W-1:0] data_mem_idx;
    logic             inst_oor;
    logic             data_oor;
    logic             data_rd;
    logic             data_wr;
    logic [WORD_W-1:0] inst_word;
    logic [WORD_W-1:0] data_word;

    // Port is read-only and byte offsets are ignored, so these bits are consumed here only.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_we, inst_sram_wdata,
                             inst_sram_addr[1:0], data_sram_addr[1:0]};

    assign inst_idx = inst_sram_addr[AW+1:2];
    assign data_idx = data_sram_addr[AW+1:2];

    // Out of range when any address bit above the index is set or the index passes DEPTH.
    assign inst_oor = ((inst_sram_addr >> (AW + 2)) != 32'd0) ||
                      (32'(inst_idx) >= 32'(DEPTH));
    assign data_oor = ((data_sram_addr >> (AW + 2)) != 32'd0) ||
                      (32'(data_idx) >= 32'(DEPTH));

    // Truncated indices are only used when in range, where they equal the full index.
    assign inst_mem_idx = inst_idx[IDX_W-1:0];
    assign data_mem_idx = data_idx[IDX_W-1:0];

    assign data_rd = data_sram_en && (data_sram_we == '0);
    assign data_wr = data_sram_en && (data_sram_we != '0);

    assign inst_word = inst_oor ? OOR_DATA : mem[inst_mem_idx];
    assign data_word = data_oor ? OOR_DATA : mem[data_mem_idx];

    // The array has no reset; an edge seen while reset is asserted must not write.
    always_ff @(posedge clk) begin
        if (resetn && data_wr && !data_oor) begin
            mem[data_mem_idx] <= byte_merge(mem[data_mem_idx], data_sram_wdata, data_sram_we);
        end
    end

    // Both read ports sample the pre-write array contents, giving read-first behaviour.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_sram_rdata <= '0;
            data_sram_rdata <= '0;
            oor_err         <= 1'b0;
        end else begin
            if (inst_sram_en) begin
                inst_sram_rdata <= inst_word;
            end
            if (data_sram_en) begin
                data_sram_rdata <= data_word;
            end
            if ((inst_sram_en && inst_oor) || (data_sram_en && data_oor)) begin
                oor_err <= 1'b1;
            end
        end
    end

    sram_sat_counter #(.W(CNT_W)) u_inst_rd_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (inst_sram_en),
        .cnt    (inst_rd_cnt)
    );

    sram_sat_counter #(.W(CNT_W)) u_data_rd_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (data_rd),
        .cnt    (data_rd_cnt)
    );

    sram_sat_counter #(.W(CNT_W)) u_data_wr_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (data_wr),
        .cnt    (data_wr_cnt)
    );

endmodule

// File: tb/tb_sram_responder.sv
// Randomized and directed bench for sram_responder, compared against a word-array
// reference model that applies the bus rules directly.
module tb_sram_responder;

    localparam int          DEPTH    = 12;
    localparam int          AW       = 4;
    localparam int          CNT_W    = 3;
    localparam logic [31:0] OOR_WORD = 32'hDEAD_BEEF;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             resetn;
    logic             inst_sram_en;
    logic [3:0]       inst_sram_we;
    logic [31:0]      inst_sram_addr;
    logic [31:0]      inst_sram_wdata;
    logic [31:0]      inst_sram_rdata;
    logic             data_sram_en;
    logic [3:0]       data_sram_we;
    logic [31:0]      data_sram_addr;
    logic [31:0]      data_sram_wdata;
    logic [31:0]      data_sram_rdata;
    logic             oor_err;
    logic [CNT_W-1:0] inst_rd_cnt;
    logic [CNT_W-1:0] data_rd_cnt;
    logic [CNT_W-1:0] data_wr_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_inst;
    logic [31:0] exp_data;
    logic        exp_oor;
    int          exp_irc;
    int          exp_drc;
    int          exp_dwc;

    sram_responder #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .OOR_DATA (OOR_WORD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .oor_err         (oor_err),
        .inst_rd_cnt     (inst_rd_cnt),
        .data_rd_cnt     (data_rd_cnt),
        .data_wr_cnt     (data_wr_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".inst"}, inst_sram_rdata, exp_inst);
        checkOutput({tag, ".data"}, data_sram_rdata, exp_data);
        checkOutput({tag, ".oor"},  32'(oor_err),     32'(exp_oor));
        checkOutput({tag, ".irc"},  32'(inst_rd_cnt), 32'(exp_irc));
        checkOutput({tag, ".drc"},  32'(data_rd_cnt), 32'(exp_drc));
        checkOutput({tag, ".dwc"},  32'(data_wr_cnt), 32'(exp_dwc));
    endtask

    function automatic bit isOor(input logic [31:0] addr);
        return (addr >> 2) >= 32'(DEPTH);
    endfunction

    function automatic int bump(input int c);
        return (c < CNT_MAX) ? c + 1 : c;
    endfunction

    // One bus cycle: the model reads before it writes, then the outputs after the edge are compared.
    task automatic applyStimulus(input string tag, input logic ie, input logic [31:0] ia,
                                 input logic de, input logic [3:0] dwe,
                                 input logic [31:0] da, input logic [31:0] dwd);
        int widx;
        inst_sram_en    = ie;
        inst_sram_addr  = ia;
        inst_sram_we    = 4'($urandom);
        inst_sram_wdata = $urandom;
        data_sram_en    = de;
        data_sram_we    = dwe;
        data_sram_addr  = da;
        data_sram_wdata = dwd;
        if (ie) begin
            exp_irc  = bump(exp_irc);
            exp_inst = isOor(ia) ? OOR_WORD : model_mem[int'(ia >> 2)];
            if (isOor(ia)) exp_oor = 1'b1;
        end
        if (de) begin
            exp_data = isOor(da) ? OOR_WORD : model_mem[int'(da >> 2)];
            if (isOor(da)) exp_oor = 1'b1;
            if (dwe == 4'h0) begin
                exp_drc = bump(exp_drc);
            end else begin
                exp_dwc = bump(exp_dwc);
                if (!isOor(da)) begin
                    widx = int'(da >> 2);
                    for (int b = 0; b < 4; b++)
                        if (dwe[b]) model_mem[widx][8*b +: 8] = dwd[8*b +: 8];
                end
            end
        end
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    // Asserts reset between edges, checks that outputs cleared without waiting for a clock.
    task automatic resetPulse(input string tag);
        resetn = 1'b0;
        #2;
        exp_inst = '0;
        exp_data = '0;
        exp_oor  = 1'b0;
        exp_irc  = 0;
        exp_drc  = 0;
        exp_dwc  = 0;
        checkAll(tag);
        @(posedge clk);
        @(negedge clk);
        resetn       = 1'b1;
        inst_sram_en = 1'b0;
        data_sram_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] randAddr();
        case ($urandom_range(0, 3))
            0, 1:    return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
            2:       return 32'($urandom_range(DEPTH, (1 << AW) - 1) * 4 + $urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        inst_sram_en    = 1'b0;
        inst_sram_we    = '0;
        inst_sram_addr  = '0;
        inst_sram_wdata = '0;
        data_sram_en    = 1'b0;
        data_sram_we    = '0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        resetn          = 1'b1;
        #1;
        resetPulse("reset");

        for (int i = 0; i < DEPTH; i++)
            applyStimulus("fill", 1'b0, '0, 1'b1, 4'hF, 32'(i * 4), $urandom);

        resetPulse("reset2");
        applyStimulus("wr10", 1'b0, '0, 1'b1, 4'hF, 32'h10, 32'h1234_5678);
        applyStimulus("rd10", 1'b1, 32'h13, 1'b1, 4'h0, 32'h10, '0);
        checkOutput("rd10.lit", data_sram_rdata, 32'h1234_5678);
        checkOutput("ird13.lit", inst_sram_rdata, 32'h1234_5678);

        applyStimulus("wr20", 1'b0, '0, 1'b1, 4'hF, 32'h20, 32'hAABB_CCDD);
        applyStimulus("wr20m", 1'b0, '0, 1'b1, 4'b0101, 32'h20, 32'h1122_3344);
        applyStimulus("rd20", 1'b0, '0, 1'b1, 4'h0, 32'h20, '0);
        checkOutput("mask.lit", data_sram_rdata, 32'hAA22_CC44);

        applyStimulus("wr28", 1'b0, '0, 1'b1, 4'hF, 32'h28, 32'h0);
        applyStimulus("coll", 1'b1, 32'h28, 1'b1, 4'hF, 32'h28, 32'hFFFF_FFFF);
        checkOutput("coll.lit", inst_sram_rdata, 32'h0);
        applyStimulus("coll2", 1'b1, 32'h28, 1'b0, 4'h0, '0, '0);
        checkOutput("coll2.lit", inst_sram_rdata, 32'hFFFF_FFFF);

        // A write pending when reset drops must be lost.
        data_sram_en    = 1'b1;
        data_sram_we    = 4'hF;
        data_sram_addr  = 32'h10;
        data_sram_wdata = 32'hCAFE_F00D;
        resetPulse("midrst");
        applyStimulus("rd10b", 1'b0, '0, 1'b1, 4'h0, 32'h10, '0);
        checkOutput("masked.lit", data_sram_rdata, 32'h1234_5678);

        resetPulse("rst_oor");
        applyStimulus("idx12", 1'b1, 32'h30, 1'b1, 4'h0, 32'h2C, '0);
        checkOutput("idx12.lit", inst_sram_rdata, OOR_WORD);
        checkOutput("idx12.flag", 32'(oor_err), 32'd1);
        applyStimulus("oor_rd", 1'b0, '0, 1'b1, 4'h0, 32'h40, '0);
        checkOutput("oor.lit", data_sram_rdata, OOR_WORD);
        applyStimulus("oor_wr", 1'b0, '0, 1'b1, 4'hF, 32'h44, 32'h5);
        applyStimulus("idx1", 1'b1, 32'h4, 1'b0, 4'h0, '0, '0);

        resetPulse("rst_cnt");
        for (int k = 0; k < 10; k++)
            applyStimulus("rd_sat", 1'b0, '0, 1'b1, 4'h0, 32'((k % DEPTH) * 4), '0);
        checkOutput("rd_sat.lit", 32'(data_rd_cnt), 32'd7);
        for (int k = 0; k < 3; k++)
            applyStimulus("idle", 1'b0, $urandom, 1'b0, 4'hF, randAddr(), $urandom);
        resetPulse("rst_cnt2");
        applyStimulus("cw", 1'b1, 32'h8, 1'b1, 4'h3, 32'h8, $urandom);
        applyStimulus("cr", 1'b1, 32'h8, 1'b0, 4'h0, '0, '0);
        checkOutput("wr_cnt.lit", 32'(data_wr_cnt), 32'd1);
        checkOutput("inst_cnt.lit", 32'(inst_rd_cnt), 32'd2);

        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                resetPulse("rnd_rst");
            end else begin
                applyStimulus("rnd", 1'($urandom_range(0, 1)), randAddr(),
                              1'($urandom_range(0, 1)),
                              ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                              randAddr(), $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
